perf_counter_bank: RTL and testbench

- Parametrised multi-channel event counter bank for pipeline performance monitoring: flushes, stalls, cache misses, branch mispredicts.
- Each channel accepts a multi-bit increment per cycle, so several same-cycle events can be credited at once.
- Provides wrap or saturate mode, sticky overflow, per-channel clear, a global snapshot, and a registered read mux.
- Sits beside the datapath; its outputs are observed only by the testbench or debug logic.

---
 rtl/perf_counter_bank.sv | 86 ++++++++
 tb/tb_perf_counter_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank: per-channel multi-bit increment, wrap/saturate, sticky overflow, snapshot.
// Latency: counters update on the clock edge after their inputs are sampled; the read port is registered (1 cycle).
// Backpressure: none, because every input is accepted on every cycle.
module perf_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 32,
    parameter int INC_W    = 2,
    parameter bit SATURATE = 1'b0,
    parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH*INC_W-1:0] inc,
    input  logic [NUM_CH-1:0]       clr,
    input  logic                    snap,
    input  logic [SEL_W-1:0]        rd_sel,
    input  logic                    rd_shadow,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_ovf,
    output logic [NUM_CH-1:0]       ovf
);

    logic [NUM_CH-1:0][WIDTH-1:0] cnt;
    logic [NUM_CH-1:0][WIDTH-1:0] shadow;
    logic [NUM_CH-1:0][WIDTH-1:0] cnt_nxt;
    logic [NUM_CH-1:0][WIDTH:0]   sum;
    logic [NUM_CH-1:0]            ovf_q;
    logic [NUM_CH-1:0]            ovf_nxt;
    logic [WIDTH-1:0]             rd_mux;
    logic                         rd_ovf_mux;

    // The sum carries one extra bit so that its MSB is exactly the overflow condition.
    always_comb begin
        sum     = '0;
        cnt_nxt = cnt;
        ovf_nxt = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, cnt[i]} + {{(WIDTH + 1 - INC_W){1'b0}}, inc[i*INC_W +: INC_W]};
            if (clr[i]) begin
                cnt_nxt[i] = '0;
                ovf_nxt[i] = 1'b0;
            end else if (enable) begin
                if (sum[i][WIDTH]) begin
                    ovf_nxt[i] = 1'b1;
                    cnt_nxt[i] = SATURATE ? {WIDTH{1'b1}} : sum[i][WIDTH-1:0];
                end else begin
                    cnt_nxt[i] = sum[i][WIDTH-1:0];
                end
            end
        end
    end

    // A select value that matches no channel leaves the mux at zero.
    always_comb begin
        rd_mux     = '0;
        rd_ovf_mux = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux     = rd_shadow ? shadow[i] : cnt[i];
                rd_ovf_mux = ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            shadow  <= '0;
            ovf_q   <= '0;
            rd_data <= '0;
            rd_ovf  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            ovf_q   <= ovf_nxt;
            rd_data <= rd_mux;
            rd_ovf  <= rd_ovf_mux;
            if (snap) begin
                shadow <= cnt;
            end
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default instance, a 4-bit wrapping 3-channel instance
// and a 4-bit saturating 2-channel instance share clock and reset.
module tb_perf_counter_bank;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic        d_enable, d_snap, d_rd_shadow, d_rd_ovf;
    logic [7:0]  d_inc;
    logic [3:0]  d_clr, d_ovf;
    logic [1:0]  d_rd_sel;
    logic [31:0] d_rd_data;

    logic        w_enable, w_snap, w_rd_shadow, w_rd_ovf;
    logic [5:0]  w_inc;
    logic [2:0]  w_clr, w_ovf;
    logic [1:0]  w_rd_sel;
    logic [3:0]  w_rd_data;

    logic        s_enable, s_snap, s_rd_shadow, s_rd_ovf;
    logic [3:0]  s_inc;
    logic [1:0]  s_clr, s_ovf;
    logic [0:0]  s_rd_sel;
    logic [3:0]  s_rd_data;

    perf_counter_bank u_def (
        .clk(clk), .rst(rst), .enable(d_enable), .inc(d_inc), .clr(d_clr), .snap(d_snap),
        .rd_sel(d_rd_sel), .rd_shadow(d_rd_shadow), .rd_data(d_rd_data), .rd_ovf(d_rd_ovf), .ovf(d_ovf)
    );

    perf_counter_bank #(.NUM_CH(3), .WIDTH(4), .INC_W(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .enable(w_enable), .inc(w_inc), .clr(w_clr), .snap(w_snap),
        .rd_sel(w_rd_sel), .rd_shadow(w_rd_shadow), .rd_data(w_rd_data), .rd_ovf(w_rd_ovf), .ovf(w_ovf)
    );

    perf_counter_bank #(.NUM_CH(2), .WIDTH(4), .INC_W(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .enable(s_enable), .inc(s_inc), .clr(s_clr), .snap(s_snap),
        .rd_sel(s_rd_sel), .rd_shadow(s_rd_shadow), .rd_data(s_rd_data), .rd_ovf(s_rd_ovf), .ovf(s_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        d_enable = 0; d_inc = '0; d_clr = '0; d_snap = 0; d_rd_sel = '0; d_rd_shadow = 0;
        w_enable = 0; w_inc = '0; w_clr = '0; w_snap = 0; w_rd_sel = '0; w_rd_shadow = 0;
        s_enable = 0; s_inc = '0; s_clr = '0; s_snap = 0; s_rd_sel = '0; s_rd_shadow = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %0d expected 0", d_rd_data); end
        total++; if (d_rd_ovf !== 1'b0) begin bad++; $display("FAIL reset_rd_ovf: got %b expected 0", d_rd_ovf); end
        total++; if (d_ovf !== 4'b0000) begin bad++; $display("FAIL reset_ovf: got %b expected 0000", d_ovf); end
        total++; if (w_ovf !== 3'b000 || s_ovf !== 2'b00) begin bad++; $display("FAIL reset_ovf_small: got %b/%b expected 000/00", w_ovf, s_ovf); end
        tick();
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL reset_read_live: got %0d expected 0", d_rd_data); end
    endtask

    task automatic test_count();
        d_enable = 1; d_inc = 8'h09;            // ch0 +1, ch1 +2
        repeat (5) tick();
        d_enable = 0; d_inc = '0; d_rd_sel = 2'd0;
        tick();
        total++; if (d_rd_data !== 32'd5) begin bad++; $display("FAIL count_ch0: got %0d expected 5", d_rd_data); end
        d_rd_sel = 2'd1;
        tick();
        total++; if (d_rd_data !== 32'd10) begin bad++; $display("FAIL count_ch1: got %0d expected 10", d_rd_data); end
        total++; if (d_ovf !== 4'b0000) begin bad++; $display("FAIL count_ovf: got %b expected 0000", d_ovf); end
    endtask

    task automatic test_priority();
        d_enable = 1; d_inc = 8'h30;            // ch2 +3
        tick(); tick();
        d_inc = 8'h10;                          // ch2 +1 -> 7
        tick();
        d_clr = 4'b0100; d_inc = 8'h30; d_rd_sel = 2'd2;
        tick();
        total++; if (d_rd_data !== 32'd7) begin bad++; $display("FAIL prio_pre_clear_read: got %0d expected 7", d_rd_data); end
        d_clr = '0; d_enable = 0; d_inc = '0;
        tick();
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL prio_clr_wins: got %0d expected 0", d_rd_data); end
        d_enable = 0; d_inc = 8'hFF; d_rd_sel = 2'd0;
        repeat (4) tick();
        d_inc = '0;
        tick();
        total++; if (d_rd_data !== 32'd5) begin bad++; $display("FAIL prio_disabled_ch0: got %0d expected 5", d_rd_data); end
        d_rd_sel = 2'd1;
        tick();
        total++; if (d_rd_data !== 32'd10) begin bad++; $display("FAIL prio_disabled_ch1: got %0d expected 10", d_rd_data); end
    endtask

    task automatic test_wrap();
        w_enable = 1; w_inc = 6'h0F;            // ch0 +3, ch1 +3
        repeat (4) tick();                      // 12, 12
        w_inc = 6'h0E;                          // ch0 +2 -> 14, ch1 +3 -> 15
        tick();
        total++; if (w_ovf !== 3'b000) begin bad++; $display("FAIL wrap_reach_max_no_ovf: got %b expected 000", w_ovf); end
        w_inc = '0;
        tick();
        total++; if (w_ovf !== 3'b000) begin bad++; $display("FAIL wrap_zero_inc_no_ovf: got %b expected 000", w_ovf); end
        w_inc = 6'h03;                          // ch0 14+3 -> 1
        tick();
        total++; if (w_ovf !== 3'b001) begin bad++; $display("FAIL wrap_ovf_set: got %b expected 001", w_ovf); end
        w_enable = 0; w_inc = '0; w_rd_sel = 2'd0;
        tick();
        total++; if (w_rd_data !== 4'd1 || w_rd_ovf !== 1'b1) begin bad++; $display("FAIL wrap_read_ch0: got %0d/%b expected 1/1", w_rd_data, w_rd_ovf); end
        w_rd_sel = 2'd1;
        tick();
        total++; if (w_rd_data !== 4'd15 || w_rd_ovf !== 1'b0) begin bad++; $display("FAIL wrap_read_ch1: got %0d/%b expected 15/0", w_rd_data, w_rd_ovf); end
        w_enable = 1; w_inc = 6'h01;
        tick();
        w_enable = 0; w_inc = '0;
        total++; if (w_ovf !== 3'b001) begin bad++; $display("FAIL wrap_ovf_sticky: got %b expected 001", w_ovf); end
    endtask

    task automatic test_bad_select();
        w_rd_sel = 2'd3;
        tick();
        total++; if (w_rd_data !== 4'd0 || w_rd_ovf !== 1'b0) begin bad++; $display("FAIL badsel_read: got %0d/%b expected 0/0", w_rd_data, w_rd_ovf); end
        w_clr = 3'b001;
        tick();
        w_clr = '0;
        total++; if (w_ovf !== 3'b000) begin bad++; $display("FAIL wrap_clr_ovf: got %b expected 000", w_ovf); end
        w_rd_sel = 2'd0;
        tick();
        total++; if (w_rd_data !== 4'd0) begin bad++; $display("FAIL wrap_clr_cnt: got %0d expected 0", w_rd_data); end
    endtask

    task automatic test_saturate();
        s_enable = 1; s_inc = 4'h3;
        repeat (4) tick();                      // 12
        s_inc = 4'h2;                           // 14
        tick();
        total++; if (s_ovf !== 2'b00) begin bad++; $display("FAIL sat_pre_ovf: got %b expected 00", s_ovf); end
        s_inc = 4'h3;                           // clamps at 15
        tick();
        total++; if (s_ovf !== 2'b01) begin bad++; $display("FAIL sat_ovf_set: got %b expected 01", s_ovf); end
        s_inc = 4'h1;
        tick();
        s_enable = 0; s_inc = '0; s_rd_sel = 1'b0;
        tick();
        total++; if (s_rd_data !== 4'd15 || s_rd_ovf !== 1'b1) begin bad++; $display("FAIL sat_hold: got %0d/%b expected 15/1", s_rd_data, s_rd_ovf); end
    endtask

    task automatic test_snapshot();
        d_enable = 1; d_inc = 8'h03;            // ch0 5 -> 8
        tick();
        d_inc = 8'h01;                          // -> 9
        tick();
        d_inc = 8'h01; d_snap = 1; d_clr = 4'b0010;
        tick();
        idle_all();
        d_rd_shadow = 1; d_rd_sel = 2'd0;
        tick();
        total++; if (d_rd_data !== 32'd9) begin bad++; $display("FAIL snap_shadow0: got %0d expected 9", d_rd_data); end
        d_rd_sel = 2'd1;
        tick();
        total++; if (d_rd_data !== 32'd10) begin bad++; $display("FAIL snap_shadow1_pre_clear: got %0d expected 10", d_rd_data); end
        d_rd_shadow = 0; d_rd_sel = 2'd0;
        tick();
        total++; if (d_rd_data !== 32'd10) begin bad++; $display("FAIL snap_live0: got %0d expected 10", d_rd_data); end
        d_rd_sel = 2'd1;
        tick();
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL snap_live1_cleared: got %0d expected 0", d_rd_data); end
        d_clr = 4'b0001; d_rd_shadow = 1; d_rd_sel = 2'd0;
        tick();
        d_clr = '0;
        tick();
        total++; if (d_rd_data !== 32'd9) begin bad++; $display("FAIL snap_shadow_survives_clr: got %0d expected 9", d_rd_data); end
    endtask

    task automatic test_mid_reset();
        idle_all();
        w_enable = 1; w_inc = 6'h30;            // ch2 +3, six times -> 18 wraps to 2
        d_enable = 1; d_inc = 8'h05;
        repeat (6) tick();
        total++; if (w_ovf !== 3'b100) begin bad++; $display("FAIL midrst_pre_ovf: got %b expected 100", w_ovf); end
        d_rd_sel = 2'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_all();
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL midrst_rd_data: got %0d expected 0", d_rd_data); end
        total++; if (w_ovf !== 3'b000 || s_ovf !== 2'b00 || d_ovf !== 4'b0000) begin bad++; $display("FAIL midrst_ovf: got %b/%b/%b expected 000/00/0000", w_ovf, s_ovf, d_ovf); end
        d_rd_shadow = 1; d_rd_sel = 2'd0;
        tick();
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL midrst_shadow0: got %0d expected 0", d_rd_data); end
        d_rd_shadow = 0; d_rd_sel = 2'd1;
        tick();
        total++; if (d_rd_data !== 32'd0) begin bad++; $display("FAIL midrst_live1: got %0d expected 0", d_rd_data); end
        d_enable = 1; d_inc = 8'h01;
        repeat (3) tick();
        d_enable = 0; d_inc = '0; d_rd_sel = 2'd0;
        tick();
        total++; if (d_rd_data !== 32'd3) begin bad++; $display("FAIL midrst_resume: got %0d expected 3", d_rd_data); end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_count();
        test_priority();
        test_wrap();
        test_bad_select();
        test_saturate();
        test_snapshot();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
